// File: rtl/fsm_coverage_monitor.sv
// rtl/fsm_coverage_monitor.sv - passive FSM state-bus coverage, transition, illegal and stuck monitor
// Tracks visited legal states and reports the unvisited ones one at a time over a valid/ready port.
module fsm_coverage_monitor #(
  parameter int STATE_W     = 2,
  parameter int NUM_STATES  = 3,
  parameter int CNT_W       = 16,
  parameter int STUCK_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  state_vld,
  input  logic [STATE_W-1:0]    state_in,
  output logic [NUM_STATES-1:0] visited,
  output logic                  all_visited,
  output logic [CNT_W-1:0]      trans_cnt,
  output logic                  cnt_sat,
  output logic                  illegal_flag,
  output logic                  stuck_flag,
  input  logic                  rpt_req,
  output logic                  rpt_busy,
  output logic                  rpt_valid,
  input  logic                  rpt_ready,
  output logic [STATE_W-1:0]    rpt_idx,
  output logic                  rpt_done
);

  localparam int                 SC_W      = $clog2(STUCK_LIMIT + 1);
  localparam logic [STATE_W-1:0] LAST_IDX  = STATE_W'(NUM_STATES - 1);
  localparam logic [SC_W-1:0]    STUCK_MAX = SC_W'(STUCK_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EMIT, S_DONE} rpt_state_e;

  logic [NUM_STATES-1:0] visited_q, visited_d;
  logic [CNT_W-1:0]      trans_cnt_q, trans_cnt_d;
  logic                  cnt_sat_q, cnt_sat_d;
  logic                  illegal_q, illegal_d;
  logic                  stuck_flag_q, stuck_flag_d;
  logic [STATE_W-1:0]    prev_state_q, prev_state_d;
  logic                  have_prev_q, have_prev_d;
  logic [SC_W-1:0]       stuck_cnt_q, stuck_cnt_d;
  rpt_state_e            state_q, state_d;
  logic [STATE_W-1:0]    idx_q, idx_d;
  logic                  rpt_valid_q, rpt_valid_d;
  logic [STATE_W-1:0]    rpt_idx_q, rpt_idx_d;
  logic                  rpt_done_q, rpt_done_d;

  logic legal;
  logic cur_visited;
  logic idx_last;

  always_comb begin
    legal       = (int'(state_in) < NUM_STATES);
    idx_last    = (idx_q == LAST_IDX);
    cur_visited = 1'b1;
    for (int i = 0; i < NUM_STATES; i++) begin
      if (idx_q == STATE_W'(i)) cur_visited = visited_q[i];
    end
  end

  always_comb begin
    visited_d    = visited_q;
    trans_cnt_d  = trans_cnt_q;
    cnt_sat_d    = cnt_sat_q;
    illegal_d    = illegal_q;
    stuck_flag_d = stuck_flag_q;
    prev_state_d = prev_state_q;
    have_prev_d  = have_prev_q;
    stuck_cnt_d  = stuck_cnt_q;
    state_d      = state_q;
    idx_d        = idx_q;

    if (state_vld) begin
      if (!legal) begin
        illegal_d = 1'b1;
      end else begin
        for (int i = 0; i < NUM_STATES; i++) begin
          if (state_in == STATE_W'(i)) visited_d[i] = 1'b1;
        end
        if (have_prev_q) begin
          if (state_in != prev_state_q) begin
            if (trans_cnt_q != '1) trans_cnt_d = trans_cnt_q + 1'b1;
            if (trans_cnt_d == '1) cnt_sat_d = 1'b1;
            stuck_cnt_d = '0;
          end else begin
            if (stuck_cnt_q != STUCK_MAX) stuck_cnt_d = stuck_cnt_q + 1'b1;
            if (stuck_cnt_d == STUCK_MAX) stuck_flag_d = 1'b1;
          end
        end
        prev_state_d = state_in;
        have_prev_d  = 1'b1;
      end
    end

    // The scan reads the live bitmap, so states seen mid-report are skipped.
    unique case (state_q)
      S_IDLE: begin
        if (rpt_req) begin
          state_d = S_SCAN;
          idx_d   = '0;
        end
      end
      S_SCAN: begin
        if (!cur_visited)  state_d = S_EMIT;
        else if (idx_last) state_d = S_DONE;
        else               idx_d   = idx_q + 1'b1;
      end
      S_EMIT: begin
        if (rpt_ready) begin
          if (idx_last) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SCAN;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    rpt_valid_d = (state_d == S_EMIT);
    rpt_idx_d   = rpt_valid_d ? idx_d : '0;
    rpt_done_d  = (state_q == S_DONE);

    if (clear) begin
      visited_d    = '0;
      trans_cnt_d  = '0;
      cnt_sat_d    = 1'b0;
      illegal_d    = 1'b0;
      stuck_flag_d = 1'b0;
      prev_state_d = '0;
      have_prev_d  = 1'b0;
      stuck_cnt_d  = '0;
      state_d      = S_IDLE;
      idx_d        = '0;
      rpt_valid_d  = 1'b0;
      rpt_idx_d    = '0;
      rpt_done_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      visited_q    <= '0;
      trans_cnt_q  <= '0;
      cnt_sat_q    <= 1'b0;
      illegal_q    <= 1'b0;
      stuck_flag_q <= 1'b0;
      prev_state_q <= '0;
      have_prev_q  <= 1'b0;
      stuck_cnt_q  <= '0;
      state_q      <= S_IDLE;
      idx_q        <= '0;
      rpt_valid_q  <= 1'b0;
      rpt_idx_q    <= '0;
      rpt_done_q   <= 1'b0;
    end else begin
      visited_q    <= visited_d;
      trans_cnt_q  <= trans_cnt_d;
      cnt_sat_q    <= cnt_sat_d;
      illegal_q    <= illegal_d;
      stuck_flag_q <= stuck_flag_d;
      prev_state_q <= prev_state_d;
      have_prev_q  <= have_prev_d;
      stuck_cnt_q  <= stuck_cnt_d;
      state_q      <= state_d;
      idx_q        <= idx_d;
      rpt_valid_q  <= rpt_valid_d;
      rpt_idx_q    <= rpt_idx_d;
      rpt_done_q   <= rpt_done_d;
    end
  end

  assign visited      = visited_q;
  assign all_visited  = &visited_q;
  assign trans_cnt    = trans_cnt_q;
  assign cnt_sat      = cnt_sat_q;
  assign illegal_flag = illegal_q;
  assign stuck_flag   = stuck_flag_q;
  assign rpt_busy     = (state_q != S_IDLE);
  assign rpt_valid    = rpt_valid_q;
  assign rpt_idx      = rpt_idx_q;
  assign rpt_done     = rpt_done_q;

endmodule

// File: tb/tb_fsm_coverage_monitor.sv
// tb/tb_fsm_coverage_monitor.sv - scoreboard bench for fsm_coverage_monitor
// Two instances (wide counter, and narrow counter with short stuck limit) share one stimulus stream.
module tb_fsm_coverage_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       state_vld = 1'b0;
  logic [1:0] state_in = '0;
  logic       rpt_req = 1'b0;
  logic       rpt_ready = 1'b0;

  logic [2:0]  visited, visited2;
  logic        all_visited, all_visited2;
  logic [15:0] trans_cnt;
  logic [1:0]  trans_cnt2;
  logic        cnt_sat, cnt_sat2, illegal_flag, illegal_flag2, stuck_flag, stuck_flag2;
  logic        rpt_busy, rpt_busy2, rpt_valid, rpt_valid2, rpt_done, rpt_done2;
  logic [1:0]  rpt_idx, rpt_idx2;

  fsm_coverage_monitor #(.STATE_W(2), .NUM_STATES(3), .CNT_W(16), .STUCK_LIMIT(8)) dut (
    .clk(clk), .rst(rst), .clear(clear), .state_vld(state_vld), .state_in(state_in),
    .visited(visited), .all_visited(all_visited), .trans_cnt(trans_cnt), .cnt_sat(cnt_sat),
    .illegal_flag(illegal_flag), .stuck_flag(stuck_flag), .rpt_req(rpt_req), .rpt_busy(rpt_busy),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_idx(rpt_idx), .rpt_done(rpt_done));

  fsm_coverage_monitor #(.STATE_W(2), .NUM_STATES(3), .CNT_W(2), .STUCK_LIMIT(3)) dut2 (
    .clk(clk), .rst(rst), .clear(clear), .state_vld(state_vld), .state_in(state_in),
    .visited(visited2), .all_visited(all_visited2), .trans_cnt(trans_cnt2), .cnt_sat(cnt_sat2),
    .illegal_flag(illegal_flag2), .stuck_flag(stuck_flag2), .rpt_req(rpt_req), .rpt_busy(rpt_busy2),
    .rpt_valid(rpt_valid2), .rpt_ready(rpt_ready), .rpt_idx(rpt_idx2), .rpt_done(rpt_done2));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int due;
    int vis;
    int trans;
    int ill;
    int stk8;
    int stk3;
  } exp_t;

  exp_t exp_q[$];
  int   rpt_q[$];
  exp_t mon_e;

  // Reference model: plain counts over the sample history.
  bit m_seen[3];
  int m_prev, m_have, m_trans, m_run, m_ill, m_stk8, m_stk3, m_busy;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d time=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_seen[i] = 1'b0;
    m_prev = 0; m_have = 0; m_trans = 0; m_run = 0;
    m_ill = 0; m_stk8 = 0; m_stk3 = 0;
  endtask

  task automatic model_sample(input int s);
    if (s >= 3) begin
      m_ill = 1;
    end else begin
      m_seen[s] = 1'b1;
      if (m_have != 0 && s != m_prev) begin
        m_trans++;
        m_run = 1;
      end else if (m_have != 0) begin
        m_run++;
      end else begin
        m_run = 1;
      end
      m_prev = s;
      m_have = 1;
      if (m_run - 1 >= 8) m_stk8 = 1;
      if (m_run - 1 >= 3) m_stk3 = 1;
    end
  endtask

  task automatic step(input logic vld, input logic [1:0] st, input logic req,
                      input logic clr, input logic rdy);
    exp_t e;
    state_vld = vld; state_in = st; rpt_req = req; clear = clr; rpt_ready = rdy;
    if (clr) begin
      model_reset();
    end else begin
      if (vld) model_sample(int'(st));
      if (req && m_busy == 0) begin
        for (int i = 0; i < 3; i++) if (!m_seen[i]) rpt_q.push_back(i);
        rpt_q.push_back(-1);
        m_busy = 1;
      end
    end
    e.due = cyc + 1;
    e.vis = 0;
    for (int i = 0; i < 3; i++) if (m_seen[i]) e.vis += (1 << i);
    e.trans = m_trans; e.ill = m_ill; e.stk8 = m_stk8; e.stk3 = m_stk3;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (clr) begin
      rpt_q.delete();
      m_busy = 0;
    end
    state_vld = 1'b0; rpt_req = 1'b0; clear = 1'b0; rpt_ready = 1'b0;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 2'd0, 1'b0, 1'b0, rdy);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_visited"}, visited, 0);
    chk({tag, "_all_visited"}, all_visited, 0);
    chk({tag, "_trans_cnt"}, trans_cnt, 0);
    chk({tag, "_cnt_sat"}, cnt_sat, 0);
    chk({tag, "_illegal"}, illegal_flag, 0);
    chk({tag, "_stuck"}, stuck_flag, 0);
    chk({tag, "_busy"}, rpt_busy, 0);
    chk({tag, "_valid"}, rpt_valid, 0);
    chk({tag, "_idx"}, rpt_idx, 0);
    chk({tag, "_done"}, rpt_done, 0);
  endtask

  // Monitor: tracking outputs against due scoreboard entries, report port against the expected stream.
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      mon_e = exp_q.pop_front();
      chk("visited", visited, mon_e.vis);
      chk("all_visited", all_visited, (mon_e.vis == 7) ? 1 : 0);
      chk("trans_cnt", trans_cnt, (mon_e.trans > 65535) ? 65535 : mon_e.trans);
      chk("cnt_sat", cnt_sat, (mon_e.trans >= 65535) ? 1 : 0);
      chk("illegal_flag", illegal_flag, mon_e.ill);
      chk("stuck_flag", stuck_flag, mon_e.stk8);
      chk("trans_cnt_w2", trans_cnt2, (mon_e.trans > 3) ? 3 : mon_e.trans);
      chk("cnt_sat_w2", cnt_sat2, (mon_e.trans >= 3) ? 1 : 0);
      chk("stuck_flag_l3", stuck_flag2, mon_e.stk3);
      chk("illegal_flag_2", illegal_flag2, mon_e.ill);
    end
    if (rpt_done) begin
      if (rpt_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rpt_done_unexpected actual=1 required=0 time=%0t", $time);
      end else begin
        chk("rpt_done_order", rpt_q.pop_front(), -1);
        m_busy = 0;
      end
    end
    if (rpt_valid) begin
      if (rpt_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rpt_valid_unexpected actual=1 required=0 time=%0t", $time);
      end else begin
        chk("rpt_idx", rpt_idx, rpt_q[0]);
        if (rpt_ready) void'(rpt_q.pop_front());
      end
    end else begin
      chk("rpt_idx_zero", rpt_idx, 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic       vld, req, clr, rdy;
    logic [1:0] st;

    model_reset();
    m_busy = 0;
    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // 0,1,0,1 -> three transitions, states 0 and 1 visited
    step(1, 2'd0, 0, 0, 0); step(1, 2'd1, 0, 0, 0);
    step(1, 2'd0, 0, 0, 0); step(1, 2'd1, 0, 0, 0);
    idle(0);

    // all visited: report is empty, done four edges after the request edge
    step(0, 0, 0, 1, 0);
    step(1, 2'd0, 0, 0, 0); step(1, 2'd1, 0, 0, 0); step(1, 2'd2, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      idle(0);
      if (rpt_done && k == 0) k = i;
    end
    chk("empty_report_done_latency", k, 4);

    // state 2 unvisited: held on the port until ready
    step(0, 0, 0, 1, 0);
    step(1, 2'd0, 0, 0, 0); step(1, 2'd1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("busy_after_req", rpt_busy, 1);
    k = 0;
    for (int i = 0; i < 10 && !rpt_valid; i++) idle(0);
    chk("emit_valid_reached", rpt_valid, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, (i == 2), 0, 0);
      chk("emit_hold_valid", rpt_valid, 1);
      chk("emit_hold_idx", rpt_idx, 2);
    end
    step(0, 0, 0, 0, 1);
    chk("done_not_yet", rpt_done, 0);
    idle(0);
    chk("done_pulse", rpt_done, 1);
    idle(0);
    chk("done_one_cycle", rpt_done, 0);

    // illegal sample leaves tracking alone; next legal sample is the first
    step(0, 0, 0, 1, 0);
    step(1, 2'd3, 0, 0, 0);
    step(1, 2'd0, 0, 0, 0);
    idle(0);

    // stuck: nine samples of 1; then narrow counter saturation
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 9; i++) step(1, 2'd1, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) step(1, 2'(i % 2), 0, 0, 0);
    idle(0);

    // clear during EMIT aborts without rpt_done
    step(0, 0, 0, 1, 0);
    step(1, 2'd0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 10 && !rpt_valid; i++) idle(0);
    chk("clr_emit_valid_reached", rpt_valid, 1);
    step(0, 0, 0, 1, 0);
    check_all_zero("after_clear");
    k = 0;
    for (int i = 0; i < 6; i++) begin
      idle(1);
      if (rpt_done) k++;
    end
    chk("no_done_after_clear", k, 0);

    // async reset mid-report
    step(1, 2'd1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 10 && !rpt_valid; i++) idle(0);
    chk("rst_emit_valid_reached", rpt_valid, 1);
    #2;
    exp_q.delete(); rpt_q.delete();
    model_reset(); m_busy = 0;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      vld = ($urandom_range(0, 3) != 0);
      st  = ($urandom_range(0, 2) == 0) ? 2'(m_prev) : 2'($urandom_range(0, 3));
      if (m_busy != 0 && st < 2'd3 && !m_seen[st]) vld = 1'b0;
      req = (m_busy == 0) && ($urandom_range(0, 7) == 0);
      clr = ($urandom_range(0, 39) == 0);
      rdy = $urandom_range(0, 1) != 0;
      step(vld, st, req, clr, rdy);
    end

    for (int i = 0; i < 60 && m_busy != 0; i++) idle(1);
    chk("drain_report_idle", m_busy, 0);
    idle(0); idle(0);
    @(negedge clk); #1;
    chk("rpt_q_empty", rpt_q.size(), 0);
    chk("exp_q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
